// File: rtl/univ_shiftreg_n.sv
// -----------------------------------------------------------------------------
// univ_shiftreg_n
// Universal WIDTH-bit shift register with single-step operations and a
// multi-step shift engine (IDLE -> RUN -> DONE).
//
// Ports
//   clk       in   rising-edge clock
//   clr       in   synchronous active-high reset, overrides everything
//   en        in   apply one operation of 'mode' this cycle (IDLE only)
//   mode[2:0] in   000 hold, 001 lsr, 010 shl, 011 ror, 100 rol,
//                  101 load, 110 asr, 111 clear
//   sdi_msb   in   serial bit entering at WIDTH-1 on logical right shift
//   sdi_lsb   in   serial bit entering at bit 0 on left shift
//   pin       in   parallel load data
//   amt       in   multi-step shift amount
//   start     in   launch a multi-step operation of 'amt' steps
//   q         out  register contents
//   sout_lsb  out  q[0]
//   sout_msb  out  q[WIDTH-1]
//   busy      out  high while the FSM is in RUN
//   done      out  one-cycle pulse in DONE
// -----------------------------------------------------------------------------
module univ_shiftreg_n #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sdi_msb,
    input  logic             sdi_lsb,
    input  logic [WIDTH-1:0] pin,
    input  logic [CNT_W-1:0] amt,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             sout_lsb,
    output logic             sout_msb,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_RUN  = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_LSR  = 3'b001;
    localparam logic [2:0] M_SHL  = 3'b010;
    localparam logic [2:0] M_ROR  = 3'b011;
    localparam logic [2:0] M_ROL  = 3'b100;
    localparam logic [2:0] M_LOAD = 3'b101;
    localparam logic [2:0] M_ASR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_lat_q, mode_lat_d;
    logic             busy_q, done_q;

    // One operation of mode m applied to value v.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             msb_in,
        input logic             lsb_in,
        input logic [WIDTH-1:0] ld
    );
        logic [WIDTH-1:0] r;
        case (m)
            M_HOLD:  r = v;
            M_LSR:   r = {msb_in, v[WIDTH-1:1]};
            M_SHL:   r = {v[WIDTH-2:0], lsb_in};
            M_ROR:   r = {v[0], v[WIDTH-1:1]};
            M_ROL:   r = {v[WIDTH-2:0], v[WIDTH-1]};
            M_LOAD:  r = ld;
            M_ASR:   r = {v[WIDTH-1], v[WIDTH-1:1]};
            M_CLR:   r = '0;
            default: r = v;
        endcase
        return r;
    endfunction

    // Shift-class modes are the only ones that run through the multi-step engine.
    function automatic logic is_shift(input logic [2:0] m);
        logic r;
        case (m)
            M_LSR, M_SHL, M_ROR, M_ROL, M_ASR: r = 1'b1;
            default:                           r = 1'b0;
        endcase
        return r;
    endfunction

    // Next-state logic for FSM, data, step counter and latched mode.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        cnt_d      = cnt_q;
        mode_lat_d = mode_lat_q;
        case (state_q)
            ST_IDLE: begin
                if (start && is_shift(mode)) begin
                    if (amt == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        // First step happens on the launch edge; cnt holds the
                        // steps still owed, so amt=1 goes straight to DONE.
                        data_d     = step_fn(mode, data_q, sdi_msb, sdi_lsb, pin);
                        mode_lat_d = mode;
                        cnt_d      = amt - CNT_W'(1);
                        if (amt == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end else if (start || en) begin
                    // start with a non-shift mode behaves like a single en step
                    data_d = step_fn(mode, data_q, sdi_msb, sdi_lsb, pin);
                end else begin
                    data_d = data_q;
                end
            end
            ST_RUN: begin
                data_d = step_fn(mode_lat_q, data_q, sdi_msb, sdi_lsb, pin);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers; busy/done are registered decodes of the next state.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            cnt_q      <= '0;
            mode_lat_q <= M_HOLD;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            cnt_q      <= cnt_d;
            mode_lat_q <= mode_lat_d;
            busy_q     <= (state_d == ST_RUN);
            done_q     <= (state_d == ST_DONE);
        end
    end

    assign q        = data_q;
    assign sout_lsb = data_q[0];
    assign sout_msb = data_q[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_univ_shiftreg_n.sv
module tb_univ_shiftreg_n;

    logic       clk = 1'b0;
    logic       clr;
    logic       en;
    logic [2:0] mode;
    logic       sdi_msb;
    logic       sdi_lsb;
    logic [7:0] pin;
    logic [3:0] amt;
    logic       start;
    logic [7:0] q;
    logic       sout_lsb;
    logic       sout_msb;
    logic       busy;
    logic       done;

    int tests = 0;
    int fails = 0;

    univ_shiftreg_n #(.WIDTH(8), .CNT_W(4)) dut (
        .clk      (clk),
        .clr      (clr),
        .en       (en),
        .mode     (mode),
        .sdi_msb  (sdi_msb),
        .sdi_lsb  (sdi_lsb),
        .pin      (pin),
        .amt      (amt),
        .start    (start),
        .q        (q),
        .sout_lsb (sout_lsb),
        .sout_msb (sout_msb),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_st(input string tag, input logic [7:0] eq, input logic eb, input logic ed);
        check({tag, ".q"},    {24'd0, q},    {24'd0, eq});
        check({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
        check({tag, ".done"}, {31'd0, done}, {31'd0, ed});
    endtask

    initial begin
        logic [7:0] fill_bits;
        clr = 1'b1; en = 1'b0; mode = 3'b000; sdi_msb = 1'b0; sdi_lsb = 1'b0;
        pin = 8'h00; amt = 4'd0; start = 1'b0;
        tick();
        check_st("reset", 8'h00, 1'b0, 1'b0);
        clr = 1'b0;

        // Load then rotate left by 3; en/mode changes during RUN/DONE ignored
        mode = 3'b101; pin = 8'hB4; en = 1'b1;
        tick();
        check_st("load_b4", 8'hB4, 1'b0, 1'b0);
        en = 1'b0; start = 1'b1; mode = 3'b100; amt = 4'd3;
        tick();
        check_st("rol_s1", 8'h69, 1'b1, 1'b0);
        start = 1'b0; en = 1'b1; mode = 3'b111; amt = 4'd7;
        tick();
        check_st("rol_s2", 8'hD2, 1'b1, 1'b0);
        tick();
        check_st("rol_s3", 8'hA5, 1'b0, 1'b1);
        tick();
        check_st("rol_idle", 8'hA5, 1'b0, 1'b0);
        en = 1'b0; mode = 3'b000;

        // Serial fill by single-step left shifts
        clr = 1'b1;
        tick();
        check_st("clr_fill", 8'h00, 1'b0, 1'b0);
        clr = 1'b0; mode = 3'b010; en = 1'b1;
        fill_bits = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) begin
            sdi_lsb = fill_bits[i];
            tick();
        end
        en = 1'b0; sdi_lsb = 1'b0;
        check_st("fill", 8'hB2, 1'b0, 1'b0);
        check("fill.sout_msb", {31'd0, sout_msb}, 32'd1);
        check("fill.sout_lsb", {31'd0, sout_lsb}, 32'd0);

        // Arithmetic shift right by 2 from 0x90
        mode = 3'b101; pin = 8'h90; en = 1'b1;
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b110; amt = 4'd2;
        tick();
        check_st("asr_s1", 8'hC8, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_st("asr_s2", 8'hE4, 1'b0, 1'b1);
        tick();

        // Logical shift right by 2 from 0x90, sdi_msb=0
        mode = 3'b101; pin = 8'h90; en = 1'b1;
        tick();
        en = 1'b0; start = 1'b1; mode = 3'b001; amt = 4'd2; sdi_msb = 1'b0;
        tick();
        check_st("lsr_s1", 8'h48, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        check_st("lsr_s2", 8'h24, 1'b0, 1'b1);
        tick();

        // amt=1 rotate right: no busy cycle, done right away
        start = 1'b1; mode = 3'b011; amt = 4'd1;
        tick();
        check_st("ror_amt1", 8'h12, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_st("ror_amt1_idle", 8'h12, 1'b0, 1'b0);

        // amt=0: q unchanged, done pulse
        start = 1'b1; mode = 3'b010; amt = 4'd0;
        tick();
        check_st("amt0", 8'h12, 1'b0, 1'b1);
        start = 1'b0;
        tick();
        check_st("amt0_idle", 8'h12, 1'b0, 1'b0);

        // start+en together; start during RUN ignored
        start = 1'b1; en = 1'b1; mode = 3'b010; amt = 4'd2; sdi_lsb = 1'b1;
        tick();
        check_st("both_s1", 8'h25, 1'b1, 1'b0);
        mode = 3'b111; amt = 4'd5;
        tick();
        check_st("both_s2", 8'h4B, 1'b0, 1'b1);
        start = 1'b0; en = 1'b0;
        tick();
        check_st("both_idle", 8'h4B, 1'b0, 1'b0);

        // start with non-shift mode behaves as single step
        start = 1'b1; mode = 3'b101; pin = 8'h3C; amt = 4'd3;
        tick();
        check_st("start_load", 8'h3C, 1'b0, 1'b0);
        start = 1'b0;
        tick();
        check_st("start_load2", 8'h3C, 1'b0, 1'b0);

        // Reset during 4th busy cycle of amt=10 rotate
        start = 1'b1; mode = 3'b100; amt = 4'd10;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        check_st("mid_busy4", 8'hC3, 1'b1, 1'b0);
        clr = 1'b1;
        tick();
        check_st("mid_clr", 8'h00, 1'b0, 1'b0);
        clr = 1'b0;
        tick();
        check_st("mid_after", 8'h00, 1'b0, 1'b0);

        // First edge after clr accepts en
        mode = 3'b101; pin = 8'h5A; en = 1'b1;
        tick();
        check_st("post_clr_load", 8'h5A, 1'b0, 1'b0);

        // Hold for 5 cycles, then clear
        mode = 3'b000;
        for (int i = 0; i < 5; i++) tick();
        check_st("hold5", 8'h5A, 1'b0, 1'b0);
        mode = 3'b111;
        tick();
        check_st("clear", 8'h00, 1'b0, 1'b0);
        en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/univ_shiftreg_n.md
UNIV_SHIFTREG_N -- requirements
Module: univ_shiftreg_n

Interface
REQ-001 SHALL have parameter WIDTH, default 8, register width in bits (legal range >= 2).
REQ-002 SHALL have parameter CNT_W, default 4, width of the multi-step shift amount.
REQ-003 SHALL have port clk, input, 1 bit: single clock, all state updates on the rising edge.
REQ-004 SHALL have port clr, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port en, input, 1 bit: perform one single-step operation this cycle.
REQ-006 SHALL have port mode, input, 3 bits: operation select (encoding in REQ-012).
REQ-007 SHALL have port sdi_msb, input, 1 bit: serial data entering at bit WIDTH-1 on a logical right shift.
REQ-008 SHALL have port sdi_lsb, input, 1 bit: serial data entering at bit 0 on a left shift.
REQ-009 SHALL have port pin, input, WIDTH bits: parallel load data.
REQ-010 SHALL have port amt and port start, inputs, CNT_W bits and 1 bit: multi-step shift amount and start strobe.
REQ-011 SHALL have outputs q (WIDTH bits, register contents), sout_lsb (=q[0]), sout_msb (=q[WIDTH-1]), busy (1 bit) and done (1 bit).

Function
REQ-012 mode encoding SHALL be: 000 hold; 001 logical shift right (q <= {sdi_msb, q[W-1:1]}); 010 shift left (q <= {q[W-2:0], sdi_lsb}); 011 rotate right; 100 rotate left; 101 parallel load (q <= pin); 110 arithmetic shift right (MSB replicated); 111 clear (q <= 0).
REQ-013 sout_lsb and sout_msb SHALL be combinational taps of the current q, with no added latency.
REQ-014 In IDLE, en=1 with start=0 SHALL apply the mode operation exactly once at the next rising edge; en=0 SHALL hold q.
REQ-015 Modes 001, 010, 011, 100 and 110 SHALL be the shift class.
REQ-016 FSM states SHALL be IDLE, RUN and DONE; busy=1 only in RUN; done=1 only in DONE.
REQ-017 IDLE with start=1, a shift-class mode and amt>0: mode and amt SHALL be latched, the first step applied at that edge, and RUN entered with the remaining count = amt-1.
REQ-018 In RUN, one step of the latched mode SHALL be applied per cycle, with sdi_msb and sdi_lsb sampled live each cycle; when the remaining count is 0, the FSM SHALL go to DONE.
REQ-019 A multi-step operation of amt steps SHALL therefore keep busy high for amt-1 cycles (0 cycles if amt=1), with done high for exactly one cycle after the last step edge.
REQ-020 IDLE with start=1 and amt=0 SHALL leave q unchanged and enter DONE (done pulse next cycle).
REQ-021 start with a non-shift mode (000, 101, 111) SHALL be treated as en=1 single-step, with no state change and no done pulse.
REQ-022 When start=1 and en=1 in the same IDLE cycle, start SHALL take priority and en SHALL be ignored.
REQ-023 In RUN and DONE, en and start SHALL be ignored, and mode/amt changes SHALL have no effect.
REQ-024 DONE SHALL return to IDLE after one cycle unconditionally.
REQ-025 Rotations SHALL wrap modulo WIDTH; amt >= WIDTH SHALL be legal and simply perform amt steps.

Reset
REQ-026 clr=1 at a rising edge SHALL force q=0, busy=0, done=0, FSM=IDLE and the internal count to 0, overriding all other inputs.
REQ-027 clr asserted mid-RUN SHALL abort the operation immediately, with no done pulse.
REQ-028 After clr deasserts, the first rising edge SHALL accept en or start normally.

Verification (WIDTH=8, CNT_W=4)
REQ-029 Load then rotate: mode=101, pin=8'hB4, en=1 -> q=8'hB4; start, mode=100, amt=3 -> q=8'hA5 after the 3rd step, busy high 2 cycles, done one cycle.
REQ-030 Serial fill: clr, then 8 single-step left shifts (mode=010) with sdi_lsb = 1,0,1,1,0,0,1,0 -> q=8'hB2; sout_msb=1.
REQ-031 Arithmetic shift right: q=8'h90, start, mode=110, amt=2 -> q=8'hE4; the same from q=8'h90 with mode=001, sdi_msb=0 -> q=8'h24.
REQ-032 Boundaries: amt=0 start -> q unchanged, done next cycle; start and en in the same cycle -> only the multi-step runs; start during RUN -> ignored.
REQ-033 Reset mid-operation: start with amt=10, clr asserted in the 4th busy cycle -> next edge q=0, busy=0, no done pulse.
REQ-034 Clear and hold: mode=111, en=1 -> q=0; mode=000 with en=1 for 5 cycles -> q stable.
